// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator sequencer.
// Holds sizes, states, op codes, the operand bundle and digit append.
package calc_pkg;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(DIGITS + 1);

    localparam logic [BCD_W-1:0] ERR_CODE = '1;
    localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(10 ** DIGITS - 1);

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        CONV,
        SHOW,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef struct packed {
        logic [BIN_W-1:0] bin;
        logic [BCD_W-1:0] bcd;
        logic [CNT_W-1:0] cnt;
    } operand_t;

    // Append one decimal digit; digits past DIGITS are dropped.
    function automatic operand_t pushDigit(operand_t o, logic [3:0] d);
        operand_t r;
        r = o;
        if (o.cnt < CNT_W'(DIGITS)) begin
            r.bin = o.bin * BIN_W'(10) + BIN_W'(d);
            r.bcd = {o.bcd[BCD_W-5:0], d};
            r.cnt = o.cnt + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Key, ALU and display signals of the calculator sequencer.
// master = sequencer side, slave = keypad/ALU/display side.
interface calc_seq_ctrl_if;
    import calc_pkg::*;

    logic             key_vld;
    logic             key_is_num;
    logic             key_is_op;
    logic             key_is_eq;
    logic [3:0]       key_digit;
    logic [1:0]       key_op;
    logic             alu_start;
    logic [1:0]       alu_op;
    logic [BIN_W-1:0] alu_a;
    logic [BIN_W-1:0] alu_b;
    logic             alu_done;
    logic [BIN_W-1:0] alu_res;
    logic             alu_err;
    logic [BCD_W-1:0] disp_bcd;
    logic             disp_load;
    logic             disp_busy;
    logic             err_o;

    modport master (
        input  key_vld, key_is_num, key_is_op, key_is_eq,
        input  key_digit, key_op,
        output alu_start, alu_op, alu_a, alu_b,
        input  alu_done, alu_res, alu_err,
        output disp_bcd, disp_load, err_o,
        input  disp_busy
    );

    modport slave (
        output key_vld, key_is_num, key_is_op, key_is_eq,
        output key_digit, key_op,
        input  alu_start, alu_op, alu_a, alu_b,
        output alu_done, alu_res, alu_err,
        input  disp_bcd, disp_load, err_o,
        output disp_busy
    );

endinterface

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble: start loads bin, one shift per cycle.
// Ports: clk, rst (async low), start, bin -> busy, done pulse, bcd.
module calc_bin2bcd
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int CW = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] sh;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] adj;
    logic [CW-1:0]    cnt;
    logic             doneR;

    // Add-3 to every nibble >= 5 before the shift.
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh    <= '0;
            acc   <= '0;
            cnt   <= '0;
            doneR <= 1'b0;
        end else if (start) begin
            sh    <= bin;
            acc   <= '0;
            cnt   <= CW'(BIN_W);
            doneR <= 1'b0;
        end else begin
            doneR <= (cnt == CW'(1));
            if (cnt != '0) begin
                acc <= {adj[BCD_W-2:0], sh[BIN_W-1]};
                sh  <= {sh[BIN_W-2:0], 1'b0};
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign busy = (cnt != '0);
    assign done = doneR;
    assign bcd  = acc;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: operand entry, ALU launch, BCD result, display.
// Ports: clk, rst (async low), bus (master side of calc_seq_ctrl_if).
module calc_seq_ctrl
    import calc_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    calc_seq_ctrl_if.master bus
);

    state_t           state, nState;
    operand_t         opA, nA;
    operand_t         opB, nB;
    logic [1:0]       aluOp, nOp;
    logic [BIN_W-1:0] resBin, nResBin;
    logic [BCD_W-1:0] resBcd, nResBcd;
    logic [BCD_W-1:0] dispR, dispNext;
    logic             startR, startNext;
    logic             loadR, pending;
    logic             isEq, isOp, isNum;
    logic             convStart, convBusy, convDone;
    logic [BCD_W-1:0] convBcd;

    calc_bin2bcd u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (convStart),
        .bin   (bus.alu_res),
        .busy  (convBusy),
        .done  (convDone),
        .bcd   (convBcd)
    );

    // Key class decode, eq > op > num; bad digits are no event.
    always_comb begin
        isEq  = 1'b0;
        isOp  = 1'b0;
        isNum = 1'b0;
        if (bus.key_vld) begin
            priority case (1'b1)
                bus.key_is_eq:  isEq  = 1'b1;
                bus.key_is_op:  isOp  = 1'b1;
                bus.key_is_num: isNum = (bus.key_digit <= 4'd9);
                default: ;
            endcase
        end
    end

    always_comb begin
        nState    = state;
        nA        = opA;
        nB        = opB;
        nOp       = aluOp;
        nResBin   = resBin;
        nResBcd   = resBcd;
        startNext = 1'b0;
        convStart = 1'b0;
        unique case (state)
            ENTER_A: begin
                if (isOp) begin
                    nOp    = bus.key_op;
                    nB     = '0;
                    nState = ENTER_B;
                end else if (isNum) begin
                    nA = pushDigit(opA, bus.key_digit);
                end
            end
            ENTER_B: begin
                if (isEq) begin
                    startNext = 1'b1;
                    nState    = EXEC;
                end else if (isOp) begin
                    nOp = bus.key_op;
                end else if (isNum) begin
                    nB = pushDigit(opB, bus.key_digit);
                end
            end
            EXEC: begin
                if (bus.alu_done) begin
                    if (bus.alu_err || bus.alu_res > MAX_VAL) begin
                        nState = ERR;
                    end else begin
                        nResBin   = bus.alu_res;
                        convStart = !convBusy;
                        nState    = CONV;
                    end
                end
            end
            CONV: begin
                if (convDone) begin
                    nResBcd = convBcd;
                    nState  = SHOW;
                end
            end
            SHOW, ERR: begin
                if (isNum) begin
                    nA     = pushDigit('0, bus.key_digit);
                    nB     = '0;
                    nOp    = OP_ADD;
                    nState = ENTER_A;
                end else if (isOp && state == SHOW) begin
                    nA.bin = resBin;
                    nA.bcd = resBcd;
                    nA.cnt = CNT_W'(DIGITS);
                    nB     = '0;
                    nOp    = bus.key_op;
                    nState = ENTER_B;
                end
            end
            default: nState = ENTER_A;
        endcase
    end

    // Display owner follows the next state so it updates with the key.
    always_comb begin
        dispNext = '0;
        unique case (nState)
            ENTER_A:          dispNext = nA.bcd;
            ENTER_B, EXEC,
            CONV:             dispNext = nB.bcd;
            SHOW:             dispNext = nResBcd;
            ERR:              dispNext = ERR_CODE;
            default:          dispNext = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ENTER_A;
            opA     <= '0;
            opB     <= '0;
            aluOp   <= OP_ADD;
            resBin  <= '0;
            resBcd  <= '0;
            startR  <= 1'b0;
            dispR   <= '0;
            pending <= 1'b1;
            loadR   <= 1'b0;
        end else begin
            state   <= nState;
            opA     <= nA;
            opB     <= nB;
            aluOp   <= nOp;
            resBin  <= nResBin;
            resBcd  <= nResBcd;
            startR  <= startNext;
            dispR   <= dispNext;
            loadR   <= pending && !bus.disp_busy;
            // A new value re-arms; an unserved one waits out busy.
            pending <= (dispNext != dispR)
                     || (pending && bus.disp_busy);
        end
    end

    assign bus.alu_start = startR;
    assign bus.alu_op    = aluOp;
    assign bus.alu_a     = opA.bin;
    assign bus.alu_b     = opB.bin;
    assign bus.disp_bcd  = dispR;
    assign bus.disp_load = loadR;
    assign bus.err_o     = (state == ERR);

endmodule
